// File: rtl/census_pkg.sv
// Shared census types: pixel and packed-column widths, common to feeder and window.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package census_pkg;

    localparam int PIXEL_DEPTH = 9;
    localparam int BOX_WIDTH   = 3;
    localparam int PIX_W       = PIXEL_DEPTH + 1;

    typedef logic [PIX_W-1:0]           pixel_t;
    typedef logic [PIX_W*BOX_WIDTH-1:0] col_t;

endpackage

// File: rtl/census_col_feeder_if.sv
// Pixel-in / column-out bundle between the raster source and the column feeder.
// Latency: n/a (wiring only).
// Backpressure: none; pix_vld and col_vld are single-cycle strobes.
//   master: drives pix_in, pix_vld, sof; observes col_out, col_vld, he, col_idx
//   slave : the feeder, the reverse directions
interface census_col_feeder_if
    import census_pkg::*;
#(
    parameter int COL_BITS = 10
) ();

    pixel_t              pix_in;
    logic                pix_vld;
    logic                sof;
    col_t                col_out;
    logic                col_vld;
    logic                he;
    logic [COL_BITS-1:0] col_idx;

    modport master (
        output pix_in, pix_vld, sof,
        input  col_out, col_vld, he, col_idx
    );

    modport slave (
        input  pix_in, pix_vld, sof,
        output col_out, col_vld, he, col_idx
    );

endinterface

// File: rtl/census_line_buf.sv
// One line of pixels, single port, read-before-write, addressed by column.
// Latency: rd_dat 1 cycle after en; peek_dat is the combinational pre-write value.
// Backpressure: none; en gates both the read register and the write.
//   clk, reset   : clock, async active-high reset (read register only, memory is not cleared)
//   en, addr     : access strobe and column address
//   wr_dat       : value stored at addr on en
//   peek_dat     : current contents at addr, feeds the next line's write data
//   rd_dat       : registered contents at addr as they were before the write
module census_line_buf
    import census_pkg::*;
#(
    parameter int IMAGE_WIDTH = 640,
    parameter int COL_BITS    = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [COL_BITS-1:0] addr,
    input  pixel_t              wr_dat,
    output pixel_t              peek_dat,
    output pixel_t              rd_dat
);

    pixel_t mem [IMAGE_WIDTH];

    assign peek_dat = mem[addr];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_dat <= '0;
        end else if (en) begin
            rd_dat <= mem[addr];
        end
    end

endmodule

// File: rtl/census_col_feeder.sv
// Raster-to-column front end: buffers BOX_WIDTH-1 lines, emits a vertical pixel column per input.
// Latency: 1 cycle from pix_vld to col_vld/col_out/he/col_idx.
// Backpressure: none; every pix_vld produces exactly one col_vld the next cycle.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of census_col_feeder_if
// Build option CENSUS_FEEDER_ZEROPAD_EN: forces column slices above the filled rows to zero;
// otherwise those slices show stale line-memory contents (he still marks them invalid).
module census_col_feeder
    import census_pkg::*;
#(
    parameter int IMAGE_WIDTH = 640,
    parameter int COL_BITS    = 10
) (
    input  logic                clk,
    input  logic                reset,
    census_col_feeder_if.slave  bus
);

    localparam int NLINES  = BOX_WIDTH - 1;
    localparam int RF_BITS = $clog2(BOX_WIDTH);

    typedef logic [COL_BITS-1:0] colcnt_t;
    typedef logic [RF_BITS-1:0]  rf_t;

    localparam colcnt_t LAST_COL = colcnt_t'(IMAGE_WIDTH - 1);
    localparam colcnt_t HE_COL   = colcnt_t'(BOX_WIDTH - 1);
    localparam rf_t     RF_MAX   = rf_t'(BOX_WIDTH - 1);

    colcnt_t col_cnt, eff_col, col_nxt, idx_q;
    rf_t     rows_filled, eff_rf, rf_nxt;
    logic    he_nxt, he_q, vld_q;
    pixel_t  pix_q;

    // sof restarts the frame on the very pixel that carries it, so the
    // effective position is forced to row 0 / col 0 before anything else uses it.
    always_comb begin
        eff_col = bus.sof ? '0 : col_cnt;
        eff_rf  = bus.sof ? '0 : rows_filled;
        col_nxt = eff_col + colcnt_t'(1);
        rf_nxt  = eff_rf;
        if (eff_col == LAST_COL) begin
            col_nxt = '0;
            if (eff_rf != RF_MAX) begin
                rf_nxt = eff_rf + rf_t'(1);
            end
        end
        he_nxt = (eff_rf == RF_MAX) && (eff_col >= HE_COL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt     <= '0;
            rows_filled <= '0;
        end else if (bus.pix_vld) begin
            col_cnt     <= col_nxt;
            rows_filled <= rf_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= 1'b0;
            he_q  <= 1'b0;
            pix_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= bus.pix_vld;
            he_q  <= bus.pix_vld & he_nxt;
            if (bus.pix_vld) begin
                pix_q <= bus.pix_in;
                idx_q <= eff_col;
            end
        end
    end

    // Line k holds the pixel k+1 rows up; on every pixel each line takes the
    // value the line below held at this column, so the column shifts up one row.
    pixel_t line_wr   [NLINES];
    pixel_t line_peek [NLINES];
    pixel_t line_rd   [NLINES];

    genvar k;
    for (k = 0; k < NLINES; k++) begin : g_line
        if (k == 0) begin : g_head
            assign line_wr[k] = bus.pix_in;
        end else begin : g_cascade
            assign line_wr[k] = line_peek[k-1];
        end

        census_line_buf #(
            .IMAGE_WIDTH (IMAGE_WIDTH),
            .COL_BITS    (COL_BITS)
        ) u_buf (
            .clk      (clk),
            .reset    (reset),
            .en       (bus.pix_vld),
            .addr     (eff_col),
            .wr_dat   (line_wr[k]),
            .peek_dat (line_peek[k]),
            .rd_dat   (line_rd[k])
        );
    end

`ifdef CENSUS_FEEDER_ZEROPAD_EN
    // Rows filled as seen by the pixel now in the output register.
    rf_t rf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_q <= '0;
        end else if (bus.pix_vld) begin
            rf_q <= eff_rf;
        end
    end
`endif

    col_t col_c;

    always_comb begin
        col_c = '0;
        col_c[PIX_W-1:0] = pix_q;
        for (int s = 1; s < BOX_WIDTH; s++) begin
            col_c[s*PIX_W +: PIX_W] = line_rd[s-1];
`ifdef CENSUS_FEEDER_ZEROPAD_EN
            if (s > int'(rf_q)) begin
                col_c[s*PIX_W +: PIX_W] = '0;
            end
`endif
        end
    end

    assign bus.col_out = col_c;
    assign bus.col_vld = vld_q;
    assign bus.he      = he_q;
    assign bus.col_idx = idx_q;

endmodule

// File: tb/tb_census_col_feeder.sv
// Bench for census_col_feeder at IMAGE_WIDTH=8, BOX_WIDTH=3, 10-bit pixels.
// Latency: expectations are due one cycle after the pixel is driven.
// Backpressure: none; the bench drives one pixel or idle per cycle.
module tb_census_col_feeder;
    import census_pkg::*;

    localparam int IW = 8;
    localparam int CB = 3;

`ifdef CENSUS_FEEDER_ZEROPAD_EN
    localparam pixel_t STALE = 10'h000;
`else
    localparam pixel_t STALE = 10'h3FF;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    census_col_feeder_if #(.COL_BITS(CB)) bus ();

    census_col_feeder #(
        .IMAGE_WIDTH (IW),
        .COL_BITS    (CB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            due;
        logic          vld;
        col_t          col;
        logic          he;
        logic [CB-1:0] idx;
    } exp_t;

    typedef struct {
        int     row;
        int     col;
        pixel_t s0;
        pixel_t s1;
        pixel_t s2;
        logic   he;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[10];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    pixel_t        mline [2][IW];
    int            m_col = 0;
    int            m_rf  = 0;
    col_t          m_last = '0;
    logic [CB-1:0] m_lidx = '0;

    // capture of DUT columns for the table checks
    logic          cap_en = 1'b0;
    int            cap_n  = 0;
    col_t          cap_col [64];
    logic          cap_he  [64];
    logic [CB-1:0] cap_idx [64];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cyc %0d: got %h expected %h", nm, cyc, got, exp);
        end
    endtask

    // Compare every expectation that has come due against the DUT outputs.
    task automatic service();
        exp_t e;
        col_t g, x;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            g = bus.col_out;
            x = e.col;
            for (int s = 0; s < BOX_WIDTH; s++) begin
                if ($isunknown(x[s*PIX_W +: PIX_W])) begin
                    g[s*PIX_W +: PIX_W] = '0;
                    x[s*PIX_W +: PIX_W] = '0;
                end
            end
            check("col_vld", 64'(bus.col_vld), 64'(e.vld));
            check("col_out", 64'(g), 64'(x));
            check("he", 64'(bus.he), 64'(e.he));
            check("col_idx", 64'(bus.col_idx), 64'(e.idx));
            if (cap_en && e.vld && cap_n < 64) begin
                cap_col[cap_n] = bus.col_out;
                cap_he[cap_n]  = bus.he;
                cap_idx[cap_n] = bus.col_idx;
                cap_n++;
            end
        end
    endtask

    task automatic drive(input logic v, input pixel_t p, input logic s);
        exp_t   e;
        int     ec, er;
        pixel_t sl;
        @(negedge clk);
        service();
        bus.pix_vld = v;
        bus.pix_in  = p;
        bus.sof     = s;
        e.due = cyc + 1;
        if (v) begin
            ec = s ? 0 : m_col;
            er = s ? 0 : m_rf;
            e.col = '0;
            e.col[PIX_W-1:0] = p;
            for (int k = 1; k < BOX_WIDTH; k++) begin
                sl = mline[k-1][ec];
`ifdef CENSUS_FEEDER_ZEROPAD_EN
                if (k > er) sl = '0;
`endif
                e.col[k*PIX_W +: PIX_W] = sl;
            end
            e.vld = 1'b1;
            e.he  = (er == BOX_WIDTH-1) && (ec >= BOX_WIDTH-1);
            e.idx = CB'(ec);
            mline[1][ec] = mline[0][ec];
            mline[0][ec] = p;
            if (ec == IW-1) begin
                m_col = 0;
                if (er < BOX_WIDTH-1) er++;
            end else begin
                m_col = ec + 1;
            end
            m_rf   = er;
            m_last = e.col;
            m_lidx = e.idx;
        end else begin
            e.vld = 1'b0;
            e.col = m_last;
            e.he  = 1'b0;
            e.idx = m_lidx;
        end
        sbq.push_back(e);
    endtask

    // One-cycle reset pulse raised just after a falling edge.
    task automatic pulse_reset();
        exp_t e;
        @(negedge clk);
        service();
        bus.pix_vld = 1'b0;
        bus.sof     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_col_vld", 64'(bus.col_vld), 64'd0);
        check("rst_col_out", 64'(bus.col_out), 64'd0);
        check("rst_he", 64'(bus.he), 64'd0);
        check("rst_col_idx", 64'(bus.col_idx), 64'd0);
        m_col  = 0;
        m_rf   = 0;
        m_last = '0;
        m_lidx = '0;
        e.due = cyc + 1;
        e.vld = 1'b0;
        e.col = '0;
        e.he  = 1'b0;
        e.idx = '0;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // npix raster pixels from a fresh sof; value = row*IW+col (= n) or all ones.
    task automatic send_seq(input int npix, input int gap, input logic ones);
        for (int n = 0; n < npix; n++) begin
            drive(1'b1, ones ? 10'h3FF : pixel_t'(n), n == 0);
            if (gap != 0) drive(1'b0, 10'h155, 1'b0);
        end
    endtask

    task automatic check_table(input int pass);
        int n;
        for (int i = 0; i < 10; i++) begin
            n = tbl[i].row * IW + tbl[i].col;
            if (n >= cap_n) begin
                check("tbl_captured", 64'(cap_n), 64'(n + 1));
            end else begin
                check("tbl_s0", 64'(cap_col[n][PIX_W-1:0]), 64'(tbl[i].s0));
                if (pass == 0 || tbl[i].row >= 2) begin
                    check("tbl_s1", 64'(cap_col[n][2*PIX_W-1:PIX_W]), 64'(tbl[i].s1));
                    check("tbl_s2", 64'(cap_col[n][3*PIX_W-1:2*PIX_W]), 64'(tbl[i].s2));
                end
                check("tbl_he", 64'(cap_he[n]), 64'(tbl[i].he));
                check("tbl_idx", 64'(cap_idx[n]), 64'(tbl[i].col));
            end
        end
    endtask

    initial begin
        tbl[0] = '{row:0, col:0, s0:10'd0,  s1:STALE,  s2:STALE,  he:1'b0};
        tbl[1] = '{row:0, col:7, s0:10'd7,  s1:STALE,  s2:STALE,  he:1'b0};
        tbl[2] = '{row:1, col:2, s0:10'd10, s1:10'd2,  s2:STALE,  he:1'b0};
        tbl[3] = '{row:1, col:7, s0:10'd15, s1:10'd7,  s2:STALE,  he:1'b0};
        tbl[4] = '{row:2, col:0, s0:10'd16, s1:10'd8,  s2:10'd0,  he:1'b0};
        tbl[5] = '{row:2, col:1, s0:10'd17, s1:10'd9,  s2:10'd1,  he:1'b0};
        tbl[6] = '{row:2, col:2, s0:10'd18, s1:10'd10, s2:10'd2,  he:1'b1};
        tbl[7] = '{row:2, col:5, s0:10'd21, s1:10'd13, s2:10'd5,  he:1'b1};
        tbl[8] = '{row:3, col:1, s0:10'd25, s1:10'd17, s2:10'd9,  he:1'b0};
        tbl[9] = '{row:3, col:7, s0:10'd31, s1:10'd23, s2:10'd15, he:1'b1};

        for (int l = 0; l < 2; l++)
            for (int c = 0; c < IW; c++)
                mline[l][c] = 'x;

        bus.pix_vld = 1'b0;
        bus.pix_in  = '0;
        bus.sof     = 1'b0;

        // reset held for three cycles, outputs must be zero
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("init_col_vld", 64'(bus.col_vld), 64'd0);
        check("init_col_out", 64'(bus.col_out), 64'd0);
        check("init_he", 64'(bus.he), 64'd0);
        check("init_col_idx", 64'(bus.col_idx), 64'd0);
        #2;
        reset = 1'b0;
        repeat (3) drive(1'b0, 10'h2AA, 1'b0);

        // fill line memory with all-ones, then reset: memory survives
        send_seq(3*IW, 0, 1'b1);
        pulse_reset();

        // continuous frame
        cap_en = 1'b1;
        cap_n  = 0;
        send_seq(4*IW, 0, 1'b0);
        drive(1'b0, 10'h0, 1'b0);
        @(negedge clk);
        service();
        cap_en = 1'b0;
        check_table(0);

        // same frame with a gap after every pixel
        cap_en = 1'b1;
        cap_n  = 0;
        send_seq(4*IW, 1, 1'b0);
        @(negedge clk);
        service();
        cap_en = 1'b0;
        check_table(1);

        // sof arriving at row 3 col 4
        send_seq(3*IW + 4, 0, 1'b0);
        drive(1'b1, 10'd200, 1'b1);
        drive(1'b0, 10'd0, 1'b0);
        check("sof_mid_vld", 64'(bus.col_vld), 64'd1);
        check("sof_mid_idx", 64'(bus.col_idx), 64'd0);
        check("sof_mid_he", 64'(bus.he), 64'd0);
        for (int n = 1; n < 3*IW; n++) drive(1'b1, pixel_t'(200 + n), 1'b0);

        // reset mid line 4, then a fresh frame
        send_seq(4*IW + 4, 0, 1'b0);
        pulse_reset();
        drive(1'b0, 10'h0, 1'b0);
        cap_en = 1'b1;
        cap_n  = 0;
        send_seq(4*IW, 0, 1'b0);
        drive(1'b0, 10'h0, 1'b0);
        @(negedge clk);
        service();
        cap_en = 1'b0;
        check_table(2);

        repeat (2) drive(1'b0, 10'h0, 1'b0);
        @(negedge clk);
        service();
        check("sb_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
